// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load-use hazard detection
// and a saturating stall-cycle counter.
module if_id_stage #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_instr_addr,
    input  logic [31:0]       if_instr,
    input  logic              flush,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    output logic [ADDR_W-1:0] id_instr_addr,
    output logic [31:0]       id_instr,
    output logic              id_valid,
    output logic              pc_stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic [10:0] op;
    logic        is_r, use_rn, use_rt, match, hazard;

    always_comb begin
        op     = id_instr[31:21];
        is_r   = (op == 11'b10101011000) || (op == 11'b11101011000);
        use_rn = is_r || (id_instr[31:22] == 10'b1001000100)
              || (op == 11'b11111000010) || (op == 11'b11111000000);
        use_rt = (op == 11'b11111000000) || (id_instr[31:24] == 8'b10110100);
        match  = (use_rn && id_instr[9:5] == ex_rd)
              || (is_r && id_instr[20:16] == ex_rd)
              || (use_rt && id_instr[4:0] == ex_rd);
        // X31 reads as XZR, so a load targeting it never creates a dependency
        hazard   = id_valid && ex_mem_read && (ex_rd != 5'd31) && match;
        pc_stall = hazard && !flush;
        bubble   = hazard && !flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_instr_addr <= '0;
            id_instr      <= '0;
            id_valid      <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            if (flush) begin
                id_instr_addr <= if_instr_addr;
                id_instr      <= '0;
                id_valid      <= 1'b0;
            end else if (!hazard) begin
                id_instr_addr <= if_instr_addr;
                id_instr      <= if_instr;
                id_valid      <= 1'b1;
            end
            if (pc_stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule
